// File: rtl/fpu_exc_pkg.sv
// Shared types for the FPU exception controller: IEEE flag vector, flag bit
// positions and the trap FSM state encoding.
package fpu_exc_pkg;

    localparam int unsigned FLAG_W   = 5;
    localparam int unsigned FLAG_INV = 4;
    localparam int unsigned FLAG_DBZ = 3;
    localparam int unsigned FLAG_OVF = 2;
    localparam int unsigned FLAG_UNF = 1;
    localparam int unsigned FLAG_INX = 0;

    localparam int unsigned TRAP_CNT_W = 16;

    typedef logic [FLAG_W-1:0] ieee_flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } exc_state_t;

    // Flags of one lane that are enabled to trap.
    function automatic ieee_flags_t trap_mask(input ieee_flags_t flags, input ieee_flags_t en);
        return flags & en;
    endfunction

endpackage

// File: rtl/fpu_exc_lane.sv
// Per-lane IEEE flag derivation from rounder status (purely combinational).
module fpu_exc_lane
    import fpu_exc_pkg::*;
(
    input  logic        lane_en,
    input  logic        nan,
    input  logic        inf,
    input  logic        zero,
    input  logic        ovf,
    input  logic        tiny,
    input  logic        inv,
    input  logic        dbz,
    input  logic        siginx,
    input  logic        ovf_en,
    input  logic        unf_en,
    output ieee_flags_t flags_c
);

    logic spec_c;
    logic inx_c;

    // Special results suppress ovf/unf/inx; masked overflow forces inexact.
    always_comb begin
        flags_c = '0;
        spec_c  = nan | inf | zero;
        inx_c   = siginx | (ovf & ~ovf_en);
        if (lane_en) begin
            flags_c[FLAG_INV] = inv;
            flags_c[FLAG_DBZ] = dbz;
            flags_c[FLAG_OVF] = ~spec_c & ovf;
            flags_c[FLAG_UNF] = ~spec_c & tiny & (unf_en | inx_c);
            flags_c[FLAG_INX] = ~spec_c & inx_c;
        end
    end

endmodule

// File: rtl/fpu_exc_ctrl.sv
// Multi-lane IEEE exception controller: flag pipeline stage, sticky register
// and handshaked trap request. Define FPU_EXC_TRAP_COUNT_EN to add trap_cnt.
module fpu_exc_ctrl
    import fpu_exc_pkg::*;
#(
    parameter int unsigned LANES  = 2,
    parameter int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      lane_en,
    input  logic [LANES-1:0]      nan,
    input  logic [LANES-1:0]      inf,
    input  logic [LANES-1:0]      zero,
    input  logic [LANES-1:0]      ovf,
    input  logic [LANES-1:0]      tiny,
    input  logic [LANES-1:0]      inv,
    input  logic [LANES-1:0]      dbz,
    input  logic [LANES-1:0]      siginx,
    input  logic                  ovf_en,
    input  logic                  unf_en,
    input  logic [FLAG_W-1:0]     trap_en,
    input  logic                  clr_sticky,
    output logic                  out_valid,
    output logic [5*LANES-1:0]    ieee_p,
    output logic [FLAG_W-1:0]     sticky,
    output logic                  trap_req,
    output logic [FLAG_W-1:0]     trap_cause,
    output logic [LANE_W-1:0]     trap_lane,
`ifdef FPU_EXC_TRAP_COUNT_EN
    output logic [TRAP_CNT_W-1:0] trap_cnt,
`endif
    input  logic                  trap_ack
);

    ieee_flags_t [LANES-1:0] lane_flags_c;

    exc_state_t              state_q, state_d;
    logic                    out_valid_q, out_valid_d;
    ieee_flags_t [LANES-1:0] ieee_p_q, ieee_p_d;
    ieee_flags_t             sticky_q, sticky_d;
    ieee_flags_t             trap_cause_q, trap_cause_d;
    logic [LANE_W-1:0]       trap_lane_q, trap_lane_d;
    logic                    pend_again_q, pend_again_d;
    ieee_flags_t             pa_cause_q, pa_cause_d;
    logic [LANE_W-1:0]       pa_lane_q, pa_lane_d;

    logic                    accept_c;
    logic                    enter_pend_c;
    logic                    hit_any_c;
    logic                    hit_vld_c;
    logic [LANE_W-1:0]       hit_lane_c;
    ieee_flags_t             hit_cause_c;
    ieee_flags_t             lanes_or_c;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        fpu_exc_lane u_lane (
            .lane_en (lane_en[i]),
            .nan     (nan[i]),
            .inf     (inf[i]),
            .zero    (zero[i]),
            .ovf     (ovf[i]),
            .tiny    (tiny[i]),
            .inv     (inv[i]),
            .dbz     (dbz[i]),
            .siginx  (siginx[i]),
            .ovf_en  (ovf_en),
            .unf_en  (unf_en),
            .flags_c (lane_flags_c[i])
        );
    end

    assign in_ready = (state_q == IDLE);
    assign trap_req = (state_q == PEND);
    assign accept_c = in_valid & in_ready;

    // OR of registered lane flags and lowest-indexed trapping lane.
    always_comb begin
        lanes_or_c  = '0;
        hit_any_c   = 1'b0;
        hit_lane_c  = '0;
        hit_cause_c = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            lanes_or_c = lanes_or_c | ieee_p_q[i];
            if (trap_mask(ieee_p_q[i], trap_en) != '0) begin
                hit_any_c   = 1'b1;
                hit_lane_c  = LANE_W'(i);
                hit_cause_c = trap_mask(ieee_p_q[i], trap_en);
            end
        end
        hit_vld_c = out_valid_q & hit_any_c;
    end

    // Next-state, pipeline and sticky logic.
    always_comb begin
        state_d      = state_q;
        out_valid_d  = accept_c;
        ieee_p_d     = accept_c ? lane_flags_c : ieee_p_q;
        trap_cause_d = trap_cause_q;
        trap_lane_d  = trap_lane_q;
        pend_again_d = pend_again_q;
        pa_cause_d   = pa_cause_q;
        pa_lane_d    = pa_lane_q;
        enter_pend_c = 1'b0;

        if (clr_sticky) begin
            sticky_d = out_valid_q ? lanes_or_c : '0;
        end else if (out_valid_q) begin
            sticky_d = sticky_q | lanes_or_c;
        end else begin
            sticky_d = sticky_q;
        end

        case (state_q)
            IDLE: begin
                if (pend_again_q) begin
                    // Trap deferred while the previous one was pending.
                    state_d      = PEND;
                    enter_pend_c = 1'b1;
                    trap_cause_d = pa_cause_q;
                    trap_lane_d  = pa_lane_q;
                    pend_again_d = hit_vld_c;
                    if (hit_vld_c) begin
                        pa_cause_d = hit_cause_c;
                        pa_lane_d  = hit_lane_c;
                    end
                end else if (hit_vld_c) begin
                    state_d      = PEND;
                    enter_pend_c = 1'b1;
                    trap_cause_d = hit_cause_c;
                    trap_lane_d  = hit_lane_c;
                end
            end
            PEND: begin
                if (hit_vld_c && !pend_again_q) begin
                    pend_again_d = 1'b1;
                    pa_cause_d   = hit_cause_c;
                    pa_lane_d    = hit_lane_c;
                end
                if (trap_ack) begin
                    state_d      = IDLE;
                    trap_cause_d = '0;
                    trap_lane_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            ieee_p_q     <= '0;
            sticky_q     <= '0;
            trap_cause_q <= '0;
            trap_lane_q  <= '0;
            pend_again_q <= 1'b0;
            pa_cause_q   <= '0;
            pa_lane_q    <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            ieee_p_q     <= ieee_p_d;
            sticky_q     <= sticky_d;
            trap_cause_q <= trap_cause_d;
            trap_lane_q  <= trap_lane_d;
            pend_again_q <= pend_again_d;
            pa_cause_q   <= pa_cause_d;
            pa_lane_q    <= pa_lane_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign ieee_p     = ieee_p_q;
    assign sticky     = sticky_q;
    assign trap_cause = trap_cause_q;
    assign trap_lane  = trap_lane_q;

`ifdef FPU_EXC_TRAP_COUNT_EN
    logic [TRAP_CNT_W-1:0] trap_cnt_q, trap_cnt_d;

    // Saturating count of trap entries; clear wins except over a same-cycle entry.
    always_comb begin
        trap_cnt_d = trap_cnt_q;
        if (clr_sticky) begin
            trap_cnt_d = enter_pend_c ? TRAP_CNT_W'(1) : '0;
        end else if (enter_pend_c && (trap_cnt_q != '1)) begin
            trap_cnt_d = trap_cnt_q + TRAP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_cnt_q <= '0;
        end else begin
            trap_cnt_q <= trap_cnt_d;
        end
    end

    assign trap_cnt = trap_cnt_q;
`endif

endmodule

// File: tb/tb_fpu_exc_ctrl.sv
// Directed self-checking bench for fpu_exc_ctrl with two lanes.
module tb_fpu_exc_ctrl;

    localparam int unsigned LANES  = 2;
    localparam int unsigned LANE_W = 1;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES-1:0]     lane_en;
    logic [LANES-1:0]     nan, inf, zero, ovf, tiny, inv, dbz, siginx;
    logic                 ovf_en, unf_en;
    logic [4:0]           trap_en;
    logic                 clr_sticky;
    logic                 out_valid;
    logic [5*LANES-1:0]   ieee_p;
    logic [4:0]           sticky;
    logic                 trap_req;
    logic [4:0]           trap_cause;
    logic [LANE_W-1:0]    trap_lane;
    logic                 trap_ack;
`ifdef FPU_EXC_TRAP_COUNT_EN
    logic [15:0]          trap_cnt;
`endif

    int n_vec;
    int n_err;

    fpu_exc_ctrl #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lane_en    (lane_en),
        .nan        (nan),
        .inf        (inf),
        .zero       (zero),
        .ovf        (ovf),
        .tiny       (tiny),
        .inv        (inv),
        .dbz        (dbz),
        .siginx     (siginx),
        .ovf_en     (ovf_en),
        .unf_en     (unf_en),
        .trap_en    (trap_en),
        .clr_sticky (clr_sticky),
        .out_valid  (out_valid),
        .ieee_p     (ieee_p),
        .sticky     (sticky),
        .trap_req   (trap_req),
        .trap_cause (trap_cause),
        .trap_lane  (trap_lane),
`ifdef FPU_EXC_TRAP_COUNT_EN
        .trap_cnt   (trap_cnt),
`endif
        .trap_ack   (trap_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid   = 1'b0;
        lane_en    = 2'b11;
        nan        = '0;
        inf        = '0;
        zero       = '0;
        ovf        = '0;
        tiny       = '0;
        inv        = '0;
        dbz        = '0;
        siginx     = '0;
        ovf_en     = 1'b0;
        unf_en     = 1'b0;
        trap_en    = '0;
        clr_sticky = 1'b0;
        trap_ack   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #12;
        n_vec++;
        if ({out_valid, ieee_p, sticky, trap_req, trap_cause, trap_lane} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_state got ov=%b p=%b s=%b tr=%b c=%b l=%b exp all zero",
                     out_valid, ieee_p, sticky, trap_req, trap_cause, trap_lane);
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ovf_inexact();
        clear_inputs();
        ovf      = 2'b01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || ieee_p !== 10'b00000_00101) begin
            n_err++;
            $display("FAIL ovf_flags got ov=%b p=%b exp ov=1 p=0000000101", out_valid, ieee_p);
        end
        step();
        n_vec++;
        if (sticky !== 5'b00101 || out_valid !== 1'b0 || trap_req !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_sticky got s=%b ov=%b tr=%b exp s=00101 ov=0 tr=0", sticky, out_valid, trap_req);
        end
        n_vec++;
        if (ieee_p !== 10'b00000_00101) begin
            n_err++;
            $display("FAIL ieee_p_hold got %b exp 0000000101", ieee_p);
        end
    endtask

    task automatic test_special_suppress();
        clear_inputs();
        tiny     = 2'b10;
        siginx   = 2'b10;
        nan      = 2'b10;
        in_valid = 1'b1;
        step();
        n_vec++;
        if (ieee_p[9:5] !== 5'b00000) begin
            n_err++;
            $display("FAIL nan_suppress got %b exp 00000", ieee_p[9:5]);
        end
        nan = 2'b00;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (ieee_p[9:5] !== 5'b00011 || ieee_p[4:0] !== 5'b00000) begin
            n_err++;
            $display("FAIL tiny_inexact got %b exp 0001100000", ieee_p);
        end
        step();
        n_vec++;
        if (sticky !== 5'b00111) begin
            n_err++;
            $display("FAIL sticky_accum got %b exp 00111", sticky);
        end
    endtask

    task automatic test_lane_disable();
        clear_inputs();
        lane_en  = 2'b01;
        inv      = 2'b10;
        dbz      = 2'b10;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (ieee_p !== 10'd0) begin
            n_err++;
            $display("FAIL lane_disable got %b exp 0000000000", ieee_p);
        end
        step();
    endtask

    task automatic test_dbz_trap();
        clear_inputs();
        trap_en  = 5'b01000;
        dbz      = 2'b10;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (trap_req !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL dbz_early got tr=%b ov=%b exp tr=0 ov=1", trap_req, out_valid);
        end
        step();
        n_vec++;
        if (trap_req !== 1'b1 || trap_lane !== 1'b1 || trap_cause !== 5'b01000 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL dbz_trap got tr=%b l=%b c=%b rdy=%b exp tr=1 l=1 c=01000 rdy=0",
                     trap_req, trap_lane, trap_cause, in_ready);
        end
        dbz      = 2'b00;
        inv      = 2'b01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || trap_req !== 1'b1) begin
            n_err++;
            $display("FAIL pend_ignores_input got ov=%b tr=%b exp ov=0 tr=1", out_valid, trap_req);
        end
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        n_vec++;
        if (trap_req !== 1'b0 || trap_cause !== 5'd0 || trap_lane !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL dbz_ack got tr=%b c=%b l=%b rdy=%b exp tr=0 c=0 l=0 rdy=1",
                     trap_req, trap_cause, trap_lane, in_ready);
        end
    endtask

    task automatic test_inv_both_lanes();
        clear_inputs();
        trap_en  = 5'b10000;
        inv      = 2'b11;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_vec++;
        if (trap_req !== 1'b1 || trap_lane !== 1'b0 || trap_cause !== 5'b10000) begin
            n_err++;
            $display("FAIL inv_lowest got tr=%b l=%b c=%b exp tr=1 l=0 c=10000", trap_req, trap_lane, trap_cause);
        end
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        step();
        n_vec++;
        if (trap_req !== 1'b0) begin
            n_err++;
            $display("FAIL inv_release got tr=%b exp 0", trap_req);
        end
    endtask

    task automatic test_clr_sticky();
        clear_inputs();
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        n_vec++;
        if (sticky !== 5'd0) begin
            n_err++;
            $display("FAIL clr_alone got %b exp 00000", sticky);
        end
        siginx   = 2'b01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        siginx   = 2'b00;
        step();
        n_vec++;
        if (sticky !== 5'b00001) begin
            n_err++;
            $display("FAIL sticky_inx got %b exp 00001", sticky);
        end
        ovf      = 2'b01;
        ovf_en   = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid   = 1'b0;
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        n_vec++;
        if (sticky !== 5'b00100) begin
            n_err++;
            $display("FAIL clr_with_valid got %b exp 00100", sticky);
        end
    endtask

    task automatic test_ack_idle();
        clear_inputs();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        n_vec++;
        if (trap_req !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL ack_in_idle got tr=%b rdy=%b exp tr=0 rdy=1", trap_req, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        trap_en  = 5'b10000;
        inv      = 2'b01;
        in_valid = 1'b1;
        step();
        inv = 2'b10;
        step();
        in_valid = 1'b0;
        inv      = 2'b00;
        n_vec++;
        if (trap_req !== 1'b1 || trap_lane !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first got tr=%b l=%b ov=%b exp tr=1 l=0 ov=1", trap_req, trap_lane, out_valid);
        end
        step();
        n_vec++;
        if (trap_req !== 1'b1 || trap_lane !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_hold got tr=%b l=%b exp tr=1 l=0", trap_req, trap_lane);
        end
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        n_vec++;
        if (trap_req !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_ack got tr=%b exp 0", trap_req);
        end
        step();
        n_vec++;
        if (trap_req !== 1'b1 || trap_lane !== 1'b1 || trap_cause !== 5'b10000) begin
            n_err++;
            $display("FAIL pend_again got tr=%b l=%b c=%b exp tr=1 l=1 c=10000", trap_req, trap_lane, trap_cause);
        end
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        step();
        n_vec++;
        if (trap_req !== 1'b0) begin
            n_err++;
            $display("FAIL pend_again_done got tr=%b exp 0", trap_req);
        end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        trap_en  = 5'b01000;
        dbz      = 2'b01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        n_vec++;
        if (trap_req !== 1'b1 || sticky === 5'd0) begin
            n_err++;
            $display("FAIL areset_setup got tr=%b s=%b exp tr=1 s=nonzero", trap_req, sticky);
        end
        rst_n = 1'b0;
        #2;
        n_vec++;
        if (trap_req !== 1'b0 || sticky !== 5'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL areset_async got tr=%b s=%b ov=%b exp all 0", trap_req, sticky, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_ovf_inexact();
        test_special_suppress();
        test_lane_disable();
        test_dbz_trap();
        test_inv_both_lanes();
        test_clr_sticky();
        test_ack_idle();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_exc_ctrl.md
Name: fpu_exc_ctrl

Overview:
Multi-lane IEEE exception controller placed after the rounders of a LANES-wide FPU datapath.
- Derives per-lane IEEE flags from rounder status.
- Registers the flags as one pipeline stage.
- Accumulates a software-visible sticky flag register.
- Raises a handshaked trap request when an enabled exception fires, stalling the issue side until the trap is acknowledged.

Parameters:
LANES, 2, number of parallel rounder lanes (1..8)
LANE_W, $clog2(LANES) or 1 when LANES=1, width of trap_lane

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  lane inputs valid this cycle
in_ready  out  1  block accepts input; low while a trap is pending
lane_en  in  LANES  per-lane operation valid; a disabled lane produces zero flags
nan, inf, zero  in  LANES each  special-result indicators per lane
ovf, tiny, inv, dbz, siginx  in  LANES each  overflow, tininess, invalid, divide-by-zero, inexact significand
ovf_en, unf_en  in  1 each  masked-response select for overflow and underflow
trap_en  in  5  trap enable per flag {INV,DBZ,OVF,UNF,INX}
clr_sticky  in  1  synchronous clear of the sticky register
out_valid  out  1  registered flags valid
ieee_p  out  5*LANES  registered per-lane flags; lane i occupies bits [5i+4:5i]
sticky  out  5  accumulated flags
trap_req  out  1  trap pending
trap_cause  out  5  trapping lane flags AND trap_en
trap_lane  out  LANE_W  lowest lane index whose flags hit trap_en
trap_ack  in  1  trap consumed

Behaviour:
- Reset (async, rst_n=0): out_valid=0, ieee_p=0, sticky=0, trap_req=0, trap_cause=0, trap_lane=0, state=IDLE.
- Per lane, combinational, with lane_en gating:
  - spec = nan|inf|zero
  - INX = siginx | (ovf & ~ovf_en)
  - flags = {inv, dbz, ~spec&ovf, ~spec&tiny&(unf_en|INX), ~spec&INX}
- Accept = in_valid & in_ready. Flags are registered on accept, so latency is 1 cycle; out_valid is high the cycle after accept and low otherwise. ieee_p holds its last value when out_valid=0.
- Sticky update on out_valid: sticky <= sticky | OR over lanes of ieee_p.
  - clr_sticky alone: sticky <= 0.
  - clr_sticky together with out_valid: sticky <= new OR only; new flags win.
  - All flags accumulate, including trapping ones.
- FSM IDLE:
  - in_ready=1.
  - If out_valid and any lane has (ieee_p_lane & trap_en) != 0, go to PEND next cycle.
  - On that transition, capture trap_lane = lowest such lane and trap_cause = its masked flags.
- FSM PEND:
  - trap_req=1, in_ready=0; incoming in_valid is ignored and upstream must hold.
  - On trap_ack, go to IDLE next cycle; trap_req drops and trap_cause/trap_lane clear to 0.
  - trap_ack in IDLE has no effect.
- Trap and acceptance in the same cycle: the op accepted in the cycle that triggers PEND still completes.
  - Its flags appear next cycle and update sticky.
  - A further trap from that op is detected after return to IDLE, only if out_valid is still... Decided rule instead: a trap hit while in PEND is recorded in a 1-bit pend_again flag, which re-enters PEND (with fresh cause/lane) one cycle after ack.
- trap_en changes take effect on the next evaluation; a pending trap is not re-evaluated.

Optional Feature:
FPU_EXC_TRAP_COUNT_EN
- Defined: adds output trap_cnt[15:0], incremented on each IDLE->PEND entry, saturating at 16'hFFFF. It is cleared by rst_n and by clr_sticky; if clr_sticky and an increment coincide, the result is 1.
- Undefined: no port and no counter logic.

Decomposition:
- Package fpu_exc_pkg:
  - typedef ieee_flags_t (logic [4:0])
  - bit-index localparams FLAG_INV=4, FLAG_DBZ=3, FLAG_OVF=2, FLAG_UNF=1, FLAG_INX=0
  - enum exc_state_t {IDLE, PEND}
- Sub-module fpu_exc_lane: the combinational per-lane flag derivation, instantiated LANES times by generate.

Test Plan:
1. LANES=2, lane0 ovf=1 spec=0 ovf_en=0, trap_en=0 -> next cycle ieee_p[4:0]=5'b00101, sticky=5'b00101, no trap.
2. lane1 tiny=1 siginx=1 unf_en=0 nan=1 -> ieee_p[9:5]=5'b00000; repeat with nan=0 -> 5'b00011.
3. trap_en=5'b01000, lane1 dbz=1 -> trap_req=1 two cycles after accept, trap_lane=1, trap_cause=5'b01000, in_ready=0; trap_ack -> trap_req=0 next cycle.
4. Both lanes inv=1 with trap_en[4]=1 -> trap_lane=0, trap_cause=5'b10000.
5. sticky=5'b00001, clr_sticky together with out_valid carrying 5'b00100 -> sticky=5'b00100.
6. rst_n low while in PEND -> trap_req, sticky, out_valid all 0 immediately, without waiting for a clock edge.
